// File: rtl/control_fsm_mc_pkg.sv
// control_fsm_mc_pkg: state encoding, RV32I opcodes and datapath select codes
// shared by the multicycle control FSM and its bench-facing users.
package control_fsm_mc_pkg;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECUTER, EXECUTEI, ALUWB, JAL, BEQ
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] A_PC    = 2'b00;
    localparam logic [1:0] A_OLDPC = 2'b01;
    localparam logic [1:0] A_REG   = 2'b10;

    localparam logic [1:0] B_REG  = 2'b00;
    localparam logic [1:0] B_IMM  = 2'b01;
    localparam logic [1:0] B_FOUR = 2'b10;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

endpackage

// File: rtl/control_fsm_mc_retire_counter.sv
// retire_counter: retired-instruction counter, wraps modulo 2^RET_W.
module retire_counter #(
    parameter int RET_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [RET_W-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (en)
            count <= count + RET_W'(1);
    end

endmodule

// File: rtl/control_fsm_mc.sv
// control_fsm_mc: multicycle RV32I control FSM with Moore output decode,
// branch-qualified PCWrite and a retired-instruction counter.
module control_fsm_mc
    import control_fsm_mc_pkg::*;
#(
    parameter int RET_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             zero,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic             AdrSrc,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic             illegal_op,
    output logic [RET_W-1:0] instret
);

    state_t state, next;
    logic   pc_update, branch, ir_w, mem_w, reg_w, ill, retire;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= FETCH;
        else
            state <= next;
    end

    always_comb begin
        next      = FETCH;
        pc_update = 1'b0;
        branch    = 1'b0;
        ir_w      = 1'b0;
        mem_w     = 1'b0;
        reg_w     = 1'b0;
        ill       = 1'b0;
        retire    = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = A_PC;
        ALUSrcB   = B_REG;
        ALUOp     = ALU_ADD;
        case (state)
            FETCH: begin
                next      = DECODE;
                ir_w      = 1'b1;
                pc_update = 1'b1;
                ALUSrcB   = B_FOUR;
                ResultSrc = RES_ALURES;
            end
            DECODE: begin
                ALUSrcA = A_OLDPC;
                ALUSrcB = B_IMM;
                case (opcode)
                    OP_LW, OP_SW: next = MEMADR;
                    OP_R:         next = EXECUTER;
                    OP_IALU:      next = EXECUTEI;
                    OP_JAL:       next = JAL;
                    OP_BEQ:       next = BEQ;
                    default:      ill  = 1'b1;
                endcase
            end
            MEMADR: begin
                next    = (opcode == OP_LW) ? MEMREAD : MEMWRITE;
                ALUSrcA = A_REG;
                ALUSrcB = B_IMM;
            end
            MEMREAD: begin
                next   = MEMWB;
                AdrSrc = 1'b1;
            end
            MEMWB: begin
                ResultSrc = RES_DATA;
                reg_w     = 1'b1;
                retire    = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc = 1'b1;
                mem_w  = 1'b1;
                retire = 1'b1;
            end
            EXECUTER: begin
                next    = ALUWB;
                ALUSrcA = A_REG;
                ALUOp   = ALU_FUNCT;
            end
            EXECUTEI: begin
                next    = ALUWB;
                ALUSrcA = A_REG;
                ALUSrcB = B_IMM;
                ALUOp   = ALU_FUNCT;
            end
            ALUWB: begin
                reg_w  = 1'b1;
                retire = 1'b1;
            end
            JAL: begin
                next      = ALUWB;
                ALUSrcA   = A_OLDPC;
                ALUSrcB   = B_FOUR;
                pc_update = 1'b1;
            end
            BEQ: begin
                ALUSrcA = A_REG;
                ALUOp   = ALU_SUB;
                branch  = 1'b1;
                retire  = 1'b1;
            end
            default: next = FETCH;
        endcase
    end

    // Reset holds state at FETCH, so its write enables must be masked here.
    assign PCWrite    = reset & (pc_update | (branch & zero));
    assign IRWrite    = reset & ir_w;
    assign MemWrite   = reset & mem_w;
    assign RegWrite   = reset & reg_w;
    assign illegal_op = reset & ill;

    retire_counter #(.RET_W(RET_W)) u_ret (
        .clk   (clk),
        .reset (reset),
        .en    (retire),
        .count (instret)
    );

endmodule

// File: tb/tb_control_fsm_mc.sv
// tb_control_fsm_mc: directed instruction sequences with a per-cycle scoreboard
// of expected control vectors and retired-instruction counts (RET_W=4).
module tb_control_fsm_mc;

    // {PCWrite,IRWrite,MemWrite,RegWrite,AdrSrc,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,illegal_op}
    localparam logic [13:0] C_RST   = 14'b0000_0_10_00_10_00_0;
    localparam logic [13:0] C_FETCH = 14'b1100_0_10_00_10_00_0;
    localparam logic [13:0] C_DEC   = 14'b0000_0_00_01_01_00_0;
    localparam logic [13:0] C_DECX  = 14'b0000_0_00_01_01_00_1;
    localparam logic [13:0] C_MADR  = 14'b0000_0_00_10_01_00_0;
    localparam logic [13:0] C_MRD   = 14'b0000_1_00_00_00_00_0;
    localparam logic [13:0] C_MWB   = 14'b0001_0_01_00_00_00_0;
    localparam logic [13:0] C_MWR   = 14'b0010_1_00_00_00_00_0;
    localparam logic [13:0] C_EXR   = 14'b0000_0_00_10_00_10_0;
    localparam logic [13:0] C_EXI   = 14'b0000_0_00_10_01_10_0;
    localparam logic [13:0] C_AWB   = 14'b0001_0_00_00_00_00_0;
    localparam logic [13:0] C_JAL   = 14'b1000_0_00_01_10_00_0;
    localparam logic [13:0] C_BEQT  = 14'b1000_0_00_10_00_01_0;
    localparam logic [13:0] C_BEQN  = 14'b0000_0_00_10_00_01_0;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IA = 7'b0010011, JL = 7'b1101111, BQ = 7'b1100011;

    logic       clk = 1'b0, reset, zero;
    logic [6:0] opcode;
    logic       PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, illegal_op;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
    logic [3:0] instret;
    logic [3:0] ret;
    logic [17:0] sb[$];
    int total = 0, bad = 0;

    control_fsm_mc #(.RET_W(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .illegal_op(illegal_op), .instret(instret)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [13:0] ctl);
        logic [17:0] e;
        logic [13:0] obs;
        sb.push_back({ctl, ret});
        #1;
        e = sb.pop_front();
        obs = {PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ResultSrc,
               ALUSrcA, ALUSrcB, ALUOp, illegal_op};
        total++;
        assert (obs === e[17:4]) else begin
            bad++;
            $error("FAIL %s ctl observed=%b expected=%b", tag, obs, e[17:4]);
        end
        total++;
        assert (instret === e[3:0]) else begin
            bad++;
            $error("FAIL %s instret observed=%0d expected=%0d", tag, instret, e[3:0]);
        end
    endtask

    task automatic cyc(input string tag, input logic [13:0] ctl, input logic [6:0] op,
                       input logic z, input logic retire);
        opcode = op;
        zero   = z;
        chk(tag, ctl);
        if (retire) ret = ret + 4'd1;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; opcode = 7'd0; zero = 1'b0; ret = 4'd0;
        @(negedge clk);
        chk("reset_hold", C_RST);
        reset = 1'b1;
        cyc("lw_fetch", C_FETCH, LW, 0, 0);
        cyc("lw_dec",   C_DEC,   LW, 0, 0);
        cyc("lw_madr",  C_MADR,  LW, 0, 0);
        cyc("lw_mrd",   C_MRD,   LW, 0, 0);
        cyc("lw_mwb",   C_MWB,   LW, 1, 1);
        cyc("beq1_fetch", C_FETCH, BQ, 1, 0);
        cyc("beq1_dec",   C_DEC,   BQ, 1, 0);
        cyc("beq1_taken", C_BEQT,  BQ, 1, 1);
        cyc("beq0_fetch", C_FETCH, BQ, 1, 0);
        cyc("beq0_dec",   C_DEC,   BQ, 0, 0);
        cyc("beq0_not",   C_BEQN,  BQ, 0, 1);
        cyc("ill_fetch", C_FETCH, 7'd0, 0, 0);
        cyc("ill_dec",   C_DECX,  7'd0, 0, 0);
        cyc("sw_fetch", C_FETCH, SW, 0, 0);
        cyc("sw_dec",   C_DEC,   SW, 0, 0);
        cyc("sw_madr",  C_MADR,  SW, 0, 0);
        cyc("sw_mwr",   C_MWR,   SW, 1, 1);
        cyc("jal_fetch", C_FETCH, JL, 0, 0);
        cyc("jal_dec",   C_DEC,   JL, 0, 0);
        cyc("jal_jal",   C_JAL,   JL, 0, 0);
        cyc("jal_awb",   C_AWB,   JL, 0, 1);
        cyc("ia_fetch", C_FETCH, IA, 0, 0);
        cyc("ia_dec",   C_DEC,   IA, 0, 0);
        cyc("ia_exi",   C_EXI,   IA, 0, 0);
        cyc("ia_awb",   C_AWB,   IA, 0, 1);
        cyc("rab_fetch", C_FETCH, RT, 0, 0);
        cyc("rab_dec",   C_DEC,   RT, 0, 0);
        chk("rab_exr", C_EXR);
        #1 reset = 1'b0;
        ret = 4'd0;
        #1 chk("rab_async", C_RST);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cyc("r_fetch", C_FETCH, RT, 0, 0);
            cyc("r_dec",   C_DEC,   RT, 0, 0);
            cyc("r_exr",   C_EXR,   RT, 0, 0);
            cyc("r_awb",   C_AWB,   RT, 0, 1);
        end
        cyc("wrap_fetch", C_FETCH, 7'd0, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/control_fsm_mc.md
CONTROL_FSM_MC -- requirements
Module: control_fsm_mc

Interface
REQ-001 The block SHALL have parameter RET_W, default 32: width of the retired-instruction counter.
REQ-002 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1: asynchronous, active-low reset.
REQ-004 Port opcode, input, 7: the instruction register opcode field [6:0].
REQ-005 Port zero, input, 1: ALU zero flag from the current cycle.
REQ-006 Port PCWrite, IRWrite, MemWrite and RegWrite, output, 1 each: write enables.
REQ-007 Port AdrSrc, output, 1: memory address select, 0=PC, 1=ALUOut.
REQ-008 Port ResultSrc, output, 2: select of the downstream 3:1 result mux.
  - 00=ALUOut
  - 01=Data
  - 10=ALUResult
REQ-009 Port ALUSrcA, output, 2: ALU A select, 00=PC, 01=OldPC, 10=RegA.
REQ-010 Port ALUSrcB, output, 2: ALU B select, 00=RegB, 01=ImmExt, 10=const 4.
REQ-011 Port ALUOp, output, 2: ALU decoder class, 00=add, 01=sub, 10=funct-decoded.
REQ-012 Port illegal_op, output, 1: pulses high for an unrecognised opcode.
REQ-013 Port instret, output, RET_W: count of retired instructions.

Function
REQ-014 The block SHALL be a multicycle RV32I control FSM with these states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, JAL, BEQ.
REQ-015 The block SHALL recognise these opcodes:
  - lw=0000011
  - sw=0100011
  - R=0110011
  - I-ALU=0010011
  - jal=1101111
  - beq=1100011
REQ-016 FETCH SHALL go to DECODE unconditionally.
REQ-017 DECODE SHALL branch on opcode:
  - lw or sw -> MEMADR
  - R -> EXECUTER
  - I-ALU -> EXECUTEI
  - jal -> JAL
  - beq -> BEQ
  - any other opcode -> FETCH
REQ-018 The remaining transitions SHALL be:
  - MEMADR -> MEMREAD for lw, MEMWRITE for sw
  - MEMREAD -> MEMWB
  - EXECUTER, EXECUTEI and JAL -> ALUWB
  - MEMWB, MEMWRITE, ALUWB and BEQ -> FETCH
REQ-019 Outputs SHALL be Moore-decoded from state (except PCWrite); unlisted signals are 0, unlisted selects are 00.
  - FETCH: IRWrite=1, ALUSrcB=10, ResultSrc=10, PCUpdate=1
  - DECODE: ALUSrcA=01, ALUSrcB=01
  - MEMADR: ALUSrcA=10, ALUSrcB=01
  - MEMREAD: AdrSrc=1
  - MEMWB: ResultSrc=01, RegWrite=1
  - MEMWRITE: AdrSrc=1, MemWrite=1
  - EXECUTER: ALUSrcA=10, ALUOp=10
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10
  - ALUWB: RegWrite=1
  - JAL: ALUSrcA=01, ALUSrcB=10, PCUpdate=1
  - BEQ: ALUSrcA=10, ALUOp=01, Branch=1
REQ-020 PCWrite SHALL equal PCUpdate | (Branch & zero), combinationally in the same cycle.
REQ-021 illegal_op SHALL be 1 only while in DECODE with an unrecognised opcode.
REQ-022 Per-instruction latency SHALL be:
  - lw: 5 cycles
  - sw: 4 cycles
  - R, I-ALU and jal: 4 cycles
  - beq: 3 cycles
  - illegal opcode: 2 cycles
REQ-023 instret SHALL increment by 1 on each clock edge that leaves MEMWB, MEMWRITE, ALUWB or BEQ, and SHALL wrap modulo 2^RET_W.
REQ-024 Illegal-opcode returns SHALL NOT increment instret.
REQ-025 opcode SHALL be sampled only in DECODE and MEMADR; the block relies on the IR holding opcode stable after FETCH.

Reset
REQ-026 While reset=0, state SHALL be FETCH and instret SHALL be 0, asynchronously.
REQ-027 While reset=0, PCWrite, IRWrite, MemWrite, RegWrite and illegal_op SHALL be forced to 0; selects SHALL show FETCH values.
REQ-028 On reset deassertion, the first rising edge SHALL begin a normal FETCH.
REQ-029 Reset asserted mid-instruction (in any state) SHALL abort it without incrementing instret.

Structure
REQ-030 The state encoding (4-bit enum), the opcode constants and the ResultSrc/ALUSrcA/ALUSrcB/ALUOp codes SHALL live in a shared control package.
REQ-031 The instret counter SHALL be a separate sub-module, retire_counter, with a RET_W parameter, increment enable and wrap.
REQ-032 The block SHALL have the state register, the next-state logic and the output decode in the top module.

Verification
REQ-033 lw: reset release, opcode=0000011 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 and ResultSrc=01 in cycle 5 only; instret 0 -> 1.
REQ-034 beq with zero=1 in BEQ -> PCWrite=1 and ALUOp=01 in cycle 3; with zero=0, PCWrite=0 in cycle 3; instret increments in both cases.
REQ-035 opcode=0000000 -> illegal_op=1 in cycle 2, next state FETCH, instret unchanged.
REQ-036 Back-to-back sw then jal -> MemWrite=1 in cycle 4; PCWrite=1 in JAL (cycle 7) and RegWrite=1 in cycle 8; instret=2.
REQ-037 Reset pulled low asynchronously mid-EXECUTER -> state=FETCH, all write enables 0 immediately without waiting for a clock edge; instret=0.
REQ-038 With RET_W=4, 16 R-type instructions -> instret wraps from 15 to 0.
